divide_by_n_fsm: RTL and testbench
==================================

Name: divide_by_n_fsm

Overview:
- Programmable integer clock-enable divider; successor to the fixed divide-by-3 FSM.
- Runtime divisor, pulse or square output mode, run/stop enable, and a ready/valid divisor load applied glitch-free at period boundaries.
- Sits beside timer/clock-gen logic and feeds slow-rate enables to downstream counters and FSMs in the same clk domain.

Parameters:
- WIDTH, 8, width of divisor and internal phase counter.
- DEFAULT_DIV, 3, divisor loaded at reset; must fit in WIDTH bits.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  synchronous, active-low reset, sampled on the rising clk edge.
- en  in  1  run enable; 1 = count, 0 = stop.
- mode  in  1  output mode; 0 = pulse, 1 = square.
- div_in  in  WIDTH  new divisor value.
- load_valid  in  1  div_in is valid.
- load_ready  out  1  block can accept div_in this cycle.
- q  out  1  divided output; Moore, decoded from registers only.
- tick  out  1  one-cycle strobe at the start of every period.

Behaviour:
- States: IDLE, RUN (enum statetype). Registers: state, cnt[WIDTH-1:0], div_reg, pend_div, pend_valid.
- Effective divisor: div_eff = (div_reg < 2) ? 1 : div_reg. 0 and 1 are both treated as divide-by-1.
- Reset (reset_n=0 at an edge): state=IDLE, cnt=0, div_reg=DEFAULT_DIV, pend_valid=0. Consequently q=0, tick=0, load_ready=1. Reset overrides every other input.
- IDLE, en=1: next state RUN, cnt=0. First tick and first q high occur in the cycle after en is sampled (1-cycle latency).
- IDLE, en=0: hold state.
- RUN, en=1: cnt wraps to 0 when cnt==div_eff-1, otherwise cnt+1. This gives period = div_eff cycles.
- RUN, en=0: next state IDLE, cnt=0. The stop is immediate and the partial period is discarded.
- tick = (state==RUN) && (cnt==0).
- Pulse mode: q = tick, i.e. high 1 of div_eff cycles.
- Square mode: q = (state==RUN) && (cnt < hi), where hi = (div_eff+1)>>1, computed in WIDTH+1 bits.
  - Even divisors give 50% duty.
  - Odd divisors are high for one extra cycle (div 3: high 2, low 1).
- mode is combinational on q; changing it mid-period takes effect the same cycle, and cnt is unaffected.
- Load handshake: a transfer occurs on an edge where load_valid && load_ready. load_ready = !pend_valid.
  - In IDLE: div_reg <= div_in directly.
  - In RUN: pend_div <= div_in, pend_valid <= 1. Applied at the next wrap edge (div_reg <= pend_div, pend_valid <= 0, cnt <= 0), so no truncated or extended period is emitted.
- Transfer coinciding with a wrap edge in RUN: div_in goes straight to div_reg at that edge and pend_valid stays 0.
- en falling while pend_valid=1: pend_div is applied on the RUN->IDLE edge.
- Reset while pending: the pending value is discarded.
- load_valid while load_ready=0: ignored. The source must hold the value (standard valid/ready).

Optional Feature:
- Macro: DIVN_PERIOD_CNT_EN.
- Defined: adds output port period_cnt [15:0].
  - Increments on every RUN wrap edge (cnt returns to 0) and wraps 0xFFFF->0x0000.
  - Reset to 0; holds in IDLE.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package divn_pkg holds:
  - statetype enum {IDLE, RUN};
  - mode constants MODE_PULSE=1'b0, MODE_SQUARE=1'b1;
  - localparam PCNT_W=16.
- One sub-module, divn_load_buf: the pend_div/pend_valid holding register and load_ready generation, with apply strobe input.
- Counter, FSM and output decode stay in the top.

Test Plan:
- Reset/default: hold reset_n=0 two cycles, release with en=1, mode=0 -> q=tick=1 once every 3 cycles starting 1 cycle after release; q=0 during reset.
- Square duty: load div 4 in IDLE, en=1, mode=1 -> q pattern 1100 repeating. Load div 5 -> 11100.
- Boundary divisors: div_in=0 then 1, mode=0 -> q constantly 1 in RUN. div_in=255 -> one tick per 255 cycles.
- Mid-run load: running div 6, present div_in=2 at cnt=2 -> load_ready drops next cycle; current period completes 6 cycles; then 2-cycle periods; load_ready returns high at the wrap edge.
- Simultaneous events: load accepted on the wrap edge -> applied immediately, load_ready never drops. en falls with pending -> IDLE with new div_reg. reset_n low mid-period with pending -> div_reg=3, pend cleared.
- DIVN_PERIOD_CNT_EN build: run div 2 for 131074 cycles -> period_cnt wraps once to 1. Build without the macro -> elaborates with no period_cnt port.

Source files
------------

// File: rtl/divn_pkg.sv
// divn_pkg: shared types and constants for the programmable clock-enable
// divider (divide_by_n_fsm) and its divisor load buffer.
//   statetype   - run/stop FSM state encoding
//   MODE_*      - values of the divider's mode input
//   PCNT_W      - width of the optional completed-period counter
package divn_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } statetype;

  localparam logic MODE_PULSE  = 1'b0;
  localparam logic MODE_SQUARE = 1'b1;

  localparam int PCNT_W = 16;

endpackage

// File: rtl/divn_load_buf.sv
// divn_load_buf: one-entry holding register for a divisor accepted while the
// divider is mid-period. The top decides when a value is captured here and
// when it is applied; this block only holds it and derives load_ready.
// Ports:
//   clk, reset_n  - clock and synchronous active-low reset
//   capture       - store div_in as the pending divisor
//   apply         - pending divisor has been consumed by the top
//   div_in        - divisor presented by the load source
//   pend_div      - held divisor
//   pend_valid    - pend_div holds an unapplied value
//   load_ready    - a new divisor can be accepted this cycle
module divn_load_buf
  import divn_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             capture,
  input  logic             apply,
  input  logic [WIDTH-1:0] div_in,
  output logic [WIDTH-1:0] pend_div,
  output logic             pend_valid,
  output logic             load_ready
);

  // Apply has priority: capture is only raised while the buffer is empty,
  // so the two never need to happen on the same edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pend_div   <= '0;
      pend_valid <= 1'b0;
    end else if (apply) begin
      pend_valid <= 1'b0;
    end else if (capture) begin
      pend_div   <= div_in;
      pend_valid <= 1'b1;
    end
  end

  assign load_ready = !pend_valid;

endmodule

// File: rtl/divide_by_n_fsm.sv
// divide_by_n_fsm: programmable integer clock-enable divider.
// Produces a one-cycle tick at the start of each period of div_eff cycles
// and a divided output q in pulse or square form. New divisors arrive over a
// valid/ready handshake and only take effect at period boundaries.
// Ports:
//   clk, reset_n  - clock and synchronous active-low reset
//   en            - 1 = run, 0 = stop (partial period discarded)
//   mode          - 0 = pulse (q = tick), 1 = square
//   div_in        - new divisor; 0 and 1 both mean divide-by-1
//   load_valid    - div_in is valid
//   load_ready    - divisor can be accepted this cycle
//   q             - divided output
//   tick          - strobe on the first cycle of every period
//   period_cnt    - completed periods, wrapping (only with DIVN_PERIOD_CNT_EN)
// Build option: define DIVN_PERIOD_CNT_EN to add the period_cnt output.
module divide_by_n_fsm
  import divn_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             mode,
  input  logic [WIDTH-1:0] div_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             q,
  output logic             tick
`ifdef DIVN_PERIOD_CNT_EN
  ,
  output logic [PCNT_W-1:0] period_cnt
`endif
);

  statetype         state;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] div_reg;
  logic [WIDTH-1:0] div_eff;
  logic [WIDTH-1:0] pend_div;
  logic             pend_valid;
  logic [WIDTH:0]   hi;
  logic             wrap;
  logic             xfer;
  logic             capture;
  logic             apply;

  assign div_eff = (div_reg < WIDTH'(2)) ? WIDTH'(1) : div_reg;

  // wrap marks the edge that ends a period while running.
  assign wrap = (state == RUN) && en && (cnt == (div_eff - WIDTH'(1)));
  assign xfer = load_valid && load_ready;

  // Only a mid-period load is parked; loads on a boundary edge (wrap or
  // stop) go straight into div_reg so load_ready never drops for them.
  assign capture = xfer && (state == RUN) && en && !wrap;
  assign apply   = pend_valid && (state == RUN) && (wrap || !en);

  divn_load_buf #(
    .WIDTH(WIDTH)
  ) u_load_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .capture   (capture),
    .apply     (apply),
    .div_in    (div_in),
    .pend_div  (pend_div),
    .pend_valid(pend_valid),
    .load_ready(load_ready)
  );

  // Run/stop FSM with the phase counter and active divisor. div_reg only
  // changes in IDLE or on a period boundary, so cnt never exceeds
  // div_eff-1 and no truncated or stretched period is emitted.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      div_reg <= WIDTH'(DEFAULT_DIV);
    end else begin
      case (state)
        IDLE: begin
          if (xfer) div_reg <= div_in;
          if (en) begin
            state <= RUN;
            cnt   <= '0;
          end
        end
        RUN: begin
          if (!en || wrap) begin
            cnt <= '0;
            if (!en) state <= IDLE;
            if (pend_valid)  div_reg <= pend_div;
            else if (xfer)   div_reg <= div_in;
          end else begin
            cnt <= cnt + WIDTH'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Square high time rounds up, so odd divisors are high one extra cycle.
  // Computed one bit wider so div_eff = 2**WIDTH-1 cannot overflow.
  assign hi = ({1'b0, div_eff} + (WIDTH + 1)'(1)) >> 1;

  assign tick = (state == RUN) && (cnt == '0);
  assign q    = (mode == MODE_SQUARE) ? ((state == RUN) && ({1'b0, cnt} < hi))
                                      : tick;

`ifdef DIVN_PERIOD_CNT_EN
  // Counts completed periods; holds while stopped.
  always_ff @(posedge clk) begin
    if (!reset_n)  period_cnt <= '0;
    else if (wrap) period_cnt <= period_cnt + PCNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_divide_by_n_fsm.sv
// tb_divide_by_n_fsm: scoreboard bench for divide_by_n_fsm. Every driven
// cycle pushes the expected q/tick/load_ready for the edge it is applied
// on; a negedge monitor pops and compares. Expectations come from the
// period index k (cycles since the period train started) rather than
// from the DUT's own counter.
module tb_divide_by_n_fsm;
  import divn_pkg::*;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             en;
  logic             mode;
  logic [WIDTH-1:0] div_in;
  logic             load_valid;
  logic             load_ready;
  logic             q;
  logic             tick;
`ifdef DIVN_PERIOD_CNT_EN
  logic [PCNT_W-1:0] period_cnt;
`endif

  typedef struct packed {
    logic q;
    logic tick;
    logic ready;
  } expect_t;

  expect_t expQ[$];
  string   tagQ[$];
  expect_t curExp;
  string   curTag;
  int      checks = 0;
  int      errors = 0;

  divide_by_n_fsm #(
    .WIDTH      (WIDTH),
    .DEFAULT_DIV(3)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en),
    .mode      (mode),
    .div_in    (div_in),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .q         (q),
    .tick      (tick)
`ifdef DIVN_PERIOD_CNT_EN
    ,
    .period_cnt(period_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Scoreboard monitor: outputs are sampled on the falling edge, well away
  // from the rising edge that updated them.
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      curExp = expQ.pop_front();
      curTag = tagQ.pop_front();
      checkOutput({curTag, ".q"},     {31'd0, q},          {31'd0, curExp.q});
      checkOutput({curTag, ".tick"},  {31'd0, tick},       {31'd0, curExp.tick});
      checkOutput({curTag, ".ready"}, {31'd0, load_ready}, {31'd0, curExp.ready});
    end
  end

  // Drives one cycle of inputs, records what the next rising edge must
  // produce, and returns just after the following falling edge.
  task automatic applyStimulus(input logic rn, input logic e, input logic m,
                               input logic lv, input logic [WIDTH-1:0] d,
                               input logic eq, input logic et, input logic er,
                               input string tag);
    expect_t x;
    reset_n    = rn;
    en         = e;
    mode       = m;
    load_valid = lv;
    div_in     = d;
    x.q     = eq;
    x.tick  = et;
    x.ready = er;
    expQ.push_back(x);
    tagQ.push_back(tag);
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  // n running cycles at effective divisor div, starting at period index k0.
  task automatic runPattern(input logic m, input int div, input int n,
                            input int k0, input string tag);
    int   k;
    logic tk;
    logic qq;
    for (int i = 0; i < n; i++) begin
      k  = (k0 + i) % div;
      tk = (k == 0);
      qq = m ? (k < (div + 1) / 2) : tk;
      applyStimulus(1'b1, 1'b1, m, 1'b0, '0, qq, tk, 1'b1,
                    $sformatf("%s[%0d]", tag, i));
    end
  endtask

  task automatic stopAndLoad(input logic [WIDTH-1:0] d, input string tag);
    applyStimulus(1'b1, 1'b0, MODE_SQUARE, 1'b0, '0, 1'b0, 1'b0, 1'b1,
                  {tag, ".stop"});
    applyStimulus(1'b1, 1'b0, MODE_SQUARE, 1'b1, d, 1'b0, 1'b0, 1'b1,
                  {tag, ".load"});
  endtask

  initial begin
    // Reset held two cycles with en high: outputs stay quiet.
    applyStimulus(1'b0, 1'b1, MODE_PULSE, 1'b0, '0, 1'b0, 1'b0, 1'b1, "rst0");
    applyStimulus(1'b0, 1'b1, MODE_PULSE, 1'b0, '0, 1'b0, 1'b0, 1'b1, "rst1");
    runPattern(MODE_PULSE, 3, 9, 0, "default3");

    // Square duty for even and odd divisors.
    stopAndLoad(8'd4, "sq4");
    runPattern(MODE_SQUARE, 4, 12, 0, "square4");
    stopAndLoad(8'd5, "sq5");
    runPattern(MODE_SQUARE, 5, 15, 0, "square5");

    // Boundary divisors.
    stopAndLoad(8'd0, "d0");
    runPattern(MODE_PULSE, 1, 5, 0, "div0");
    stopAndLoad(8'd1, "d1");
    runPattern(MODE_SQUARE, 1, 3, 0, "div1sq");
    runPattern(MODE_PULSE, 1, 3, 0, "div1");
    stopAndLoad(8'd255, "d255");
    runPattern(MODE_PULSE, 255, 511, 0, "div255");

    // Mid-run load: div 6 period finishes, then 2-cycle periods.
    stopAndLoad(8'd6, "d6");
    runPattern(MODE_PULSE, 6, 3, 0, "div6");
    applyStimulus(1'b1, 1'b1, MODE_PULSE, 1'b1, 8'd2, 1'b0, 1'b0, 1'b0, "midload");
    applyStimulus(1'b1, 1'b1, MODE_PULSE, 1'b1, 8'd9, 1'b0, 1'b0, 1'b0, "busy0");
    applyStimulus(1'b1, 1'b1, MODE_PULSE, 1'b1, 8'd9, 1'b0, 1'b0, 1'b0, "busy1");
    applyStimulus(1'b1, 1'b1, MODE_PULSE, 1'b0, '0,   1'b1, 1'b1, 1'b1, "applied");
    runPattern(MODE_PULSE, 2, 3, 1, "div2");

    // Load accepted on the wrap edge takes effect at once.
    applyStimulus(1'b1, 1'b1, MODE_PULSE, 1'b1, 8'd4, 1'b1, 1'b1, 1'b1, "wrapload");
    runPattern(MODE_PULSE, 4, 4, 1, "div4");

    // Stop with a pending divisor: it lands in div_reg on the way to IDLE.
    applyStimulus(1'b1, 1'b1, MODE_PULSE, 1'b1, 8'd5, 1'b0, 1'b0, 1'b0, "pend5");
    applyStimulus(1'b1, 1'b0, MODE_PULSE, 1'b0, '0,   1'b0, 1'b0, 1'b1, "stoppend");
    runPattern(MODE_PULSE, 5, 11, 0, "div5");

    // Reset with a pending divisor: default divisor back, pending dropped.
    applyStimulus(1'b1, 1'b1, MODE_PULSE, 1'b1, 8'd7, 1'b0, 1'b0, 1'b0, "pend7");
    applyStimulus(1'b0, 1'b1, MODE_PULSE, 1'b0, '0,   1'b0, 1'b0, 1'b1, "rstpend");
    runPattern(MODE_PULSE, 3, 6, 0, "afterrst");

    // Mode switched mid-period changes q without disturbing the phase.
    stopAndLoad(8'd4, "mode");
    runPattern(MODE_SQUARE, 4, 2, 0, "modeSq");
    runPattern(MODE_PULSE,  4, 1, 2, "modePl");
    runPattern(MODE_SQUARE, 4, 3, 3, "modeSq2");

`ifdef DIVN_PERIOD_CNT_EN
    applyStimulus(1'b0, 1'b0, MODE_PULSE, 1'b0, '0, 1'b0, 1'b0, 1'b1, "pcRst");
    checkOutput("pcAfterReset", {16'd0, period_cnt}, 32'd0);
    applyStimulus(1'b1, 1'b0, MODE_PULSE, 1'b1, 8'd2, 1'b0, 1'b0, 1'b1, "pcLoad");
    runPattern(MODE_PULSE, 2, 10, 0, "pcRun");
    checkOutput("pcAfterRun", {16'd0, period_cnt}, 32'd4);
    applyStimulus(1'b1, 1'b0, MODE_PULSE, 1'b0, '0, 1'b0, 1'b0, 1'b1, "pcStop");
    applyStimulus(1'b1, 1'b0, MODE_PULSE, 1'b0, '0, 1'b0, 1'b0, 1'b1, "pcIdle");
    checkOutput("pcHold", {16'd0, period_cnt}, 32'd4);
`endif

    // Bounded drain of anything still queued.
    for (int i = 0; i < 10 && expQ.size() > 0; i++) @(negedge clk);
    #1;
    checkOutput("drain", expQ.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
